// File: rtl/alu_pkg.sv
// Shared ALU types: legacy 2-bit op, extended 4-bit op set and the sequencer FSM state.
package alu_pkg;

  localparam int unsigned ALU_OP_W = 4;

  typedef enum logic [1:0] {
    ALU_OP_ADD = 2'd0,
    ALU_OP_SUB = 2'd1,
    ALU_OP_AND = 2'd2,
    ALU_OP_OR  = 2'd3
  } alu_op_t;

  // Encodings 8..15 are undefined and yield a zero result.
  typedef enum logic [ALU_OP_W-1:0] {
    ALU_ADD = 4'd0,
    ALU_SUB = 4'd1,
    ALU_AND = 4'd2,
    ALU_OR  = 4'd3,
    ALU_XOR = 4'd4,
    ALU_SLL = 4'd5,
    ALU_SRA = 4'd6,
    ALU_MUL = 4'd7
  } alu_ext_op_t;

  typedef enum logic {
    IDLE = 1'b0,
    MUL  = 1'b1
  } alu_seq_state_t;

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative signed multiplier: shift-add on operand magnitudes, one partial product per edge.
// The final iteration's sum is presented combinationally so the caller can register it on that edge.
module alu_mul_iter #(
  parameter int unsigned DATA_WIDTH = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic [DATA_WIDTH-1:0]     a,
  input  logic [DATA_WIDTH-1:0]     b,
  output logic                      done_c,
  output logic [2*DATA_WIDTH-1:0]   product_c
);

  localparam int unsigned W  = DATA_WIDTH;
  localparam int unsigned PW = 2 * DATA_WIDTH;
  localparam int unsigned CW = $clog2(DATA_WIDTH);

  logic          active_q, active_d;
  logic          neg_q, neg_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [PW-1:0] acc_q, acc_d;
  logic [PW-1:0] mcand_q, mcand_d;
  logic [W-1:0]  mplier_q, mplier_d;

  logic [W-1:0]  a_mag_c, b_mag_c;
  logic [PW-1:0] partial_c;

  // Magnitudes fit in W unsigned bits, including the most negative operand.
  assign a_mag_c = a[W-1] ? (~a + W'(1)) : a;
  assign b_mag_c = b[W-1] ? (~b + W'(1)) : b;

  assign partial_c = acc_q + (mplier_q[0] ? mcand_q : '0);
  assign product_c = neg_q ? (~partial_c + PW'(1)) : partial_c;
  assign done_c    = active_q && (cnt_q == CW'(W - 1));

  always_comb begin
    active_d = active_q;
    neg_d    = neg_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    if (start) begin
      active_d = 1'b1;
      neg_d    = a[W-1] ^ b[W-1];
      cnt_d    = '0;
      acc_d    = '0;
      mcand_d  = PW'(a_mag_c);
      mplier_d = b_mag_c;
    end else if (active_q) begin
      acc_d    = partial_c;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q + CW'(1);
      if (done_c) begin
        active_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active_q <= 1'b0;
      neg_q    <= 1'b0;
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
    end else begin
      active_q <= active_d;
      neg_q    <= neg_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
    end
  end

endmodule

// File: rtl/alu_seq.sv
// Sequential ALU with valid/ready on both sides: single-cycle ops load the output register
// at the accept edge, MUL runs iteratively in alu_mul_iter while the input side is closed.
module alu_seq
  import alu_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  input  logic [ALU_OP_W-1:0]   op,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] result,
  output logic                  z,
  output logic                  n,
  output logic                  v,
  output logic                  c,
  output logic                  busy
);

  localparam int unsigned W  = DATA_WIDTH;
  localparam int unsigned XW = DATA_WIDTH + 1;
  localparam int unsigned SW = $clog2(DATA_WIDTH);

  alu_seq_state_t state_q, state_d;
  logic           out_valid_q, out_valid_d;
  logic [W-1:0]   result_q, result_d;
  logic           z_q, z_d, n_q, n_d, v_q, v_d, c_q, c_d;

  alu_ext_op_t    op_c;
  logic           accept_c, is_mul_c, mul_start_c, mul_done_c;
  logic [2*W-1:0] mul_prod_c;
  logic [SW-1:0]  shamt_c;
  logic [XW-1:0]  add_c, sub_c, sll_c, sra_c;
  logic [W-1:0]   alu_res_c;
  logic           alu_v_c, alu_c_c, mul_v_c;

  assign op_c        = alu_ext_op_t'(op);
  assign in_ready    = (state_q == IDLE) && (!out_valid_q || out_ready);
  assign accept_c    = in_valid && in_ready;
  assign is_mul_c    = (op_c == ALU_MUL);
  assign mul_start_c = accept_c && is_mul_c;

  alu_mul_iter #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_mul (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (mul_start_c),
    .a         (a),
    .b         (b),
    .done_c    (mul_done_c),
    .product_c (mul_prod_c)
  );

  // Overflow when the full product does not survive truncation to W bits.
  assign mul_v_c = (mul_prod_c != {{W{mul_prod_c[W-1]}}, mul_prod_c[W-1:0]});

  // Single-cycle datapath; the extra top/bottom bit of each temp carries c.
  always_comb begin
    shamt_c   = b[SW-1:0];
    add_c     = {1'b0, a} + {1'b0, b};
    sub_c     = {1'b0, a} + {1'b0, ~b} + XW'(1);
    sll_c     = {1'b0, a} << shamt_c;
    sra_c     = $signed({a, 1'b0}) >>> shamt_c;
    alu_res_c = '0;
    alu_v_c   = 1'b0;
    alu_c_c   = 1'b0;
    case (op_c)
      ALU_ADD: begin
        alu_res_c = add_c[W-1:0];
        alu_c_c   = add_c[W];
        alu_v_c   = (a[W-1] == b[W-1]) && (add_c[W-1] != a[W-1]);
      end
      ALU_SUB: begin
        alu_res_c = sub_c[W-1:0];
        alu_c_c   = sub_c[W];
        alu_v_c   = (a[W-1] != b[W-1]) && (sub_c[W-1] != a[W-1]);
      end
      ALU_AND: alu_res_c = a & b;
      ALU_OR:  alu_res_c = a | b;
      ALU_XOR: alu_res_c = a ^ b;
      ALU_SLL: begin
        alu_res_c = sll_c[W-1:0];
        alu_c_c   = sll_c[W];
      end
      ALU_SRA: begin
        alu_res_c = sra_c[W:1];
        alu_c_c   = sra_c[0];
      end
      default: begin
        alu_res_c = '0;
      end
    endcase
  end

  // Next state and output register; a drain and a load may share one edge.
  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q && !out_ready;
    result_d    = result_q;
    z_d         = z_q;
    n_d         = n_q;
    v_d         = v_q;
    c_d         = c_q;
    case (state_q)
      IDLE: begin
        if (accept_c) begin
          if (is_mul_c) begin
            state_d = MUL;
          end else begin
            out_valid_d = 1'b1;
            result_d    = alu_res_c;
            z_d         = (alu_res_c == '0);
            n_d         = alu_res_c[W-1];
            v_d         = alu_v_c;
            c_d         = alu_c_c;
          end
        end
      end
      MUL: begin
        if (mul_done_c) begin
          state_d     = IDLE;
          out_valid_d = 1'b1;
          result_d    = mul_prod_c[W-1:0];
          z_d         = (mul_prod_c[W-1:0] == '0);
          n_d         = mul_prod_c[W-1];
          v_d         = mul_v_c;
          c_d         = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      z_q         <= 1'b0;
      n_q         <= 1'b0;
      v_q         <= 1'b0;
      c_q         <= 1'b0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      z_q         <= z_d;
      n_q         <= n_d;
      v_q         <= v_d;
      c_q         <= c_d;
    end
  end

  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign z         = z_q;
  assign n         = n_q;
  assign v         = v_q;
  assign c         = c_q;
  assign busy      = (state_q == MUL);

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq (DATA_WIDTH=4): directed cases plus randomized traffic
// with random back-pressure, checked against an integer-arithmetic reference model.
module tb_alu_seq;
  import alu_pkg::*;

  typedef struct packed {
    logic [3:0] r;
    logic       z;
    logic       n;
    logic       v;
    logic       c;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid, in_ready;
  logic [3:0] a, b, op;
  logic       out_valid, out_ready;
  logic [3:0] result;
  logic       z, n, v, c, busy;

  exp_t sb[$];
  int   n_cmp  = 0;
  int   n_fail = 0;
  int   cyc    = 0;
  exp_t held;
  logic held_v = 1'b0;
  logic rnd_done;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  alu_seq #(.DATA_WIDTH(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .op        (op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .z         (z),
    .n         (n),
    .v         (v),
    .c         (c),
    .busy      (busy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model from the arithmetic rules, using plain integers.
  function automatic exp_t model(input logic [3:0] ia, input logic [3:0] ib, input logic [3:0] iop);
    int   sa, sb_, ua, ub, sh, r;
    exp_t e;
    sa = $signed(ia);
    sb_ = $signed(ib);
    ua = int'(ia);
    ub = int'(ib);
    sh = int'(ib[1:0]);
    e.v = 1'b0;
    e.c = 1'b0;
    case (iop)
      4'd0: begin r = sa + sb_; e.c = (ua + ub) > 15; e.v = (r > 7) || (r < -8); end
      4'd1: begin r = sa - sb_; e.c = (ua >= ub);     e.v = (r > 7) || (r < -8); end
      4'd2: r = ua & ub;
      4'd3: r = ua | ub;
      4'd4: r = ua ^ ub;
      4'd5: begin r = ua << sh; e.c = (sh != 0) && (((ua >> (4 - sh)) & 1) != 0); end
      4'd6: begin r = sa >>> sh; e.c = (sh != 0) && (((sa >>> (sh - 1)) & 1) != 0); end
      4'd7: begin r = sa * sb_; e.v = (r > 7) || (r < -8); end
      default: r = 0;
    endcase
    e.r = r[3:0];
    e.z = (e.r == 4'd0);
    e.n = e.r[3];
    return e;
  endfunction

  // Present one transaction, wait for acceptance, then push its expected response.
  task automatic issue(input logic [3:0] ia, input logic [3:0] ib, input logic [3:0] iop,
                       input exp_t e);
    int   k = 0;
    logic acc = 1'b0;
    in_valid = 1'b1;
    a = ia;
    b = ib;
    op = iop;
    while (!acc && k < 200) begin
      @(negedge clk);
      if (in_ready) acc = 1'b1;
      else k++;
    end
    if (!acc) begin
      n_cmp++;
      n_fail++;
      $display("FAIL accept_timeout: in_ready never rose for op %0h", iop);
      in_valid = 1'b0;
      return;
    end
    sb.push_back(e);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    a = 4'($urandom);
    b = 4'($urandom);
    op = 4'($urandom);
  endtask

  task automatic drain();
    int k = 0;
    while (sb.size() != 0 && k < 200) begin
      @(negedge clk);
      k++;
    end
    check("drain_empty", 32'(sb.size()), 32'd0);
    @(posedge clk);
    #1;
  endtask

  // Monitor: pops on every handshake and checks that a held output does not move.
  always @(negedge clk) begin
    exp_t cur, e;
    if (!rst_n) begin
      held_v = 1'b0;
    end else begin
      cur = {result, z, n, v, c};
      if (held_v) check("hold_stable", 32'(cur), 32'(held));
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL unexpected_out: got %0h with empty scoreboard", cur);
        end else begin
          e = sb.pop_front();
          check("out_value", 32'(cur), 32'(e));
        end
      end
      held_v = out_valid && !out_ready;
      held   = cur;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0;
    logic [3:0] ra, rb, rop;
    rst_n = 1'b0;
    in_valid = 1'b0;
    a = '0;
    b = '0;
    op = '0;
    out_ready = 1'b1;
    rnd_done = 1'b0;
    #12;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_result", 32'({result, z, n, v, c}), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;

    // Directed arithmetic cases with hand-derived expectations.
    issue(4'd7, 4'd1, 4'd0, '{r: 4'b1000, z: 1'b0, n: 1'b1, v: 1'b1, c: 1'b0});
    issue(4'd3, 4'd3, 4'd1, '{r: 4'b0000, z: 1'b1, n: 1'b0, v: 1'b0, c: 1'b1});
    issue(4'h8, 4'd1, 4'd1, '{r: 4'b0111, z: 1'b0, n: 1'b0, v: 1'b1, c: 1'b1});
    issue(4'b1001, 4'd1, 4'd5, '{r: 4'b0010, z: 1'b0, n: 1'b0, v: 1'b0, c: 1'b1});
    issue(4'b1000, 4'd2, 4'd6, '{r: 4'b1110, z: 1'b0, n: 1'b1, v: 1'b0, c: 1'b0});
    issue(4'd5, 4'd6, 4'hF, '{r: 4'b0000, z: 1'b1, n: 1'b0, v: 1'b0, c: 1'b0});
    drain();

    // MUL latency: busy and closed input for four cycles, result after the fourth edge.
    issue(4'hD, 4'd2, 4'd7, '{r: 4'b1010, z: 1'b0, n: 1'b1, v: 1'b0, c: 1'b0});
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("mul_busy", 32'(busy), 32'd1);
      check("mul_in_ready", 32'(in_ready), 32'd0);
      check("mul_out_valid_early", 32'(out_valid), 32'd0);
    end
    @(negedge clk);
    check("mul_out_valid_on_time", 32'(out_valid), 32'd1);
    check("mul_busy_done", 32'(busy), 32'd0);
    @(posedge clk);
    #1;
    issue(4'd4, 4'd4, 4'd7, '{r: 4'b0000, z: 1'b1, n: 1'b0, v: 1'b1, c: 1'b0});
    drain();

    // Back-pressure: first result held, second stalled, then both delivered in order.
    out_ready = 1'b0;
    issue(4'd2, 4'd3, 4'd0, '{r: 4'b0101, z: 1'b0, n: 1'b0, v: 1'b0, c: 1'b0});
    fork
      issue(4'd1, 4'd1, 4'd0, '{r: 4'b0010, z: 1'b0, n: 1'b0, v: 1'b0, c: 1'b0});
    join_none
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("bp_in_ready", 32'(in_ready), 32'd0);
      check("bp_held_result", 32'({out_valid, result}), 32'h15);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    wait fork;
    t0 = cyc;
    for (int k = 0; k < 4; k++) begin
      ra = 4'($urandom);
      rb = 4'($urandom);
      issue(ra, rb, 4'd0, model(ra, rb, 4'd0));
    end
    check("throughput_cycles", 32'(cyc - t0), 32'd4);
    drain();

    // Reset in the second MUL iteration cycle aborts everything.
    issue(4'd6, 4'd7, 4'd4, '{r: 4'b0001, z: 1'b0, n: 1'b0, v: 1'b0, c: 1'b0});
    issue(4'd3, 4'd3, 4'd7, '{r: 4'b1001, z: 1'b0, n: 1'b1, v: 1'b1, c: 1'b0});
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("abort_out_valid", 32'(out_valid), 32'd0);
    check("abort_result_flags", 32'({result, z, n, v, c}), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_in_ready", 32'(in_ready), 32'd1);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check("no_stale_result", 32'(out_valid), 32'd0);
    end
    @(posedge clk);
    #1;

    // Randomized traffic with random downstream stalls.
    fork
      begin
        for (int k = 0; k < 300; k++) begin
          ra = 4'($urandom);
          rb = 4'($urandom);
          rop = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(8, 15)) : 4'($urandom_range(0, 7));
          issue(ra, rb, rop, model(ra, rb, rop));
        end
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          out_ready = 1'($urandom_range(0, 1));
          @(posedge clk);
          #1;
        end
      end
    join
    out_ready = 1'b1;
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
